// File: rtl/ws2812_chain_ctrl_if.sv
// Host-side bundle for the WS2812 chain controller: pixel write port,
// frame request, and the status/serial outputs coming back from the controller.
interface ws2812_chain_ctrl_if #(
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              start;
  logic              busy;
  logic              done;
  logic              rgb;

  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  busy, done, rgb
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output busy, done, rgb
  );
endinterface

// File: rtl/ws2812_chain_ctrl.sv
// Frame controller for a daisy chain of WS2812-style LEDs on one data pin.
// Holds a 24-bit GRB buffer per LED, serialises the whole chain MSB-first with
// fixed-length bit cells, then holds the line low for the latch interval.
// Optional build macro WS2812_CHAIN_AUTO_REFRESH_EN: resend the frame after
// REFRESH_TICKS idle cycles without a host start.
module ws2812_chain_ctrl #(
  parameter int NUM_LEDS      = 8,
  parameter int ADDR_W        = 3,
  parameter int TICKS_T0H     = 8,
  parameter int TICKS_T1H     = 32,
  parameter int TICKS_BIT     = 40,
  parameter int TICKS_RESET   = 9000,
  parameter int REFRESH_TICKS = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  ws2812_chain_ctrl_if.slave bus
);

  localparam int LED_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int TMAX_A = (TICKS_BIT > TICKS_RESET) ? TICKS_BIT : TICKS_RESET;
  localparam int TMAX   = (TMAX_A > REFRESH_TICKS) ? TMAX_A : REFRESH_TICKS;
  localparam int TICK_W = $clog2(TMAX + 1);

  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);
  localparam logic [TICK_W-1:0] T0H_T    = TICK_W'(TICKS_T0H);
  localparam logic [TICK_W-1:0] T1H_T    = TICK_W'(TICKS_T1H);
  localparam logic [TICK_W-1:0] T0L_T    = TICK_W'(TICKS_BIT - TICKS_T0H);
  localparam logic [TICK_W-1:0] T1L_T    = TICK_W'(TICKS_BIT - TICKS_T1H);
  localparam logic [TICK_W-1:0] TRST_T   = TICK_W'(TICKS_RESET);
  localparam logic [LED_W-1:0]  LED_LAST = LED_W'(NUM_LEDS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [TICK_W-1:0] tick, tick_nxt;
  logic [23:0]       shift, shift_nxt;
  logic [4:0]        bit_idx, bit_nxt;
  logic [LED_W-1:0]  led_idx, led_nxt;
  logic              pending, pending_nxt;
  logic              done_nxt;
  logic              rgb_q, busy_q, done_q;

  logic [ADDR_W-1:0]             wr_addr;
  logic                          wr_ok;
  logic [NUM_LEDS-1:0][23:0]     pix_flat;
  logic [LED_W-1:0]              fetch_idx;
  logic [23:0]                   fetch_pix;
  logic [TICK_W-1:0]             hi_len, lo_len;
  logic                          go;

  assign wr_addr = bus.wr_addr;
  // Addresses past the end of the chain are silently dropped.
  assign wr_ok   = bus.wr_en && (32'(wr_addr) < NUM_LEDS);

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_pix
    logic [23:0] q;
    // Pixel entry g: written by the host at any time, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (wr_ok && (32'(wr_addr) == 32'(g))) begin
        q <= bus.wr_data;
      end
    end
    assign pix_flat[g] = q;
  end

  // Pick the pixel about to be loaded into the shifter; a write to that LED in
  // the same cycle wins so the host never loses a late update.
  always_comb begin
    fetch_idx = (state == S_LOAD) ? '0 : led_idx + 1'b1;
    fetch_pix = pix_flat[fetch_idx];
    if (wr_ok && (32'(wr_addr) == 32'(fetch_idx))) begin
      fetch_pix = bus.wr_data;
    end
  end

`ifdef WS2812_CHAIN_AUTO_REFRESH_EN
  localparam int RF_W = $clog2(REFRESH_TICKS + 1);
  logic [RF_W-1:0] idle_cnt;
  logic            refresh_hit;

  assign refresh_hit = (state == S_IDLE) && (idle_cnt == RF_W'(REFRESH_TICKS - 1));

  // Count consecutive idle cycles; restarts whenever the controller leaves IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if ((state != S_IDLE) || refresh_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign go = bus.start | refresh_hit;
`else
  assign go = bus.start;
`endif

  // Frame sequencer: bit cell timing, LED stepping, latch and pending requests.
  always_comb begin
    state_nxt   = state;
    tick_nxt    = tick;
    shift_nxt   = shift;
    bit_nxt     = bit_idx;
    led_nxt     = led_idx;
    pending_nxt = pending;
    done_nxt    = 1'b0;
    hi_len      = shift[23] ? T1H_T : T0H_T;
    lo_len      = shift[23] ? T1L_T : T0L_T;

    if ((state != S_IDLE) && bus.start) begin
      pending_nxt = 1'b1;
    end

    case (state)
      S_IDLE: begin
        pending_nxt = 1'b0;
        if (go) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        shift_nxt = fetch_pix;
        led_nxt   = '0;
        bit_nxt   = '0;
        tick_nxt  = TICK_ONE;
        state_nxt = S_HIGH;
      end
      S_HIGH: begin
        if (tick == hi_len) begin
          tick_nxt  = TICK_ONE;
          state_nxt = S_LOW;
        end else begin
          tick_nxt = tick + 1'b1;
        end
      end
      S_LOW: begin
        if (tick == lo_len) begin
          tick_nxt = TICK_ONE;
          if (bit_idx != 5'd23) begin
            shift_nxt = {shift[22:0], 1'b0};
            bit_nxt   = bit_idx + 1'b1;
            state_nxt = S_HIGH;
          end else if (led_idx < LED_LAST) begin
            shift_nxt = fetch_pix;
            led_nxt   = led_idx + 1'b1;
            bit_nxt   = '0;
            state_nxt = S_HIGH;
          end else begin
            state_nxt = S_LATCH;
          end
        end else begin
          tick_nxt = tick + 1'b1;
        end
      end
      S_LATCH: begin
        if (tick == TRST_T) begin
          done_nxt = 1'b1;
          if (pending || bus.start) begin
            pending_nxt = 1'b0;
            state_nxt   = S_LOAD;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          tick_nxt = tick + 1'b1;
        end
      end
      default: begin
        state_nxt   = S_IDLE;
        pending_nxt = 1'b0;
      end
    endcase
  end

  // Control state and registered outputs; rgb/busy follow the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tick    <= '0;
      bit_idx <= '0;
      led_idx <= '0;
      pending <= 1'b0;
      rgb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      tick    <= tick_nxt;
      bit_idx <= bit_nxt;
      led_idx <= led_nxt;
      pending <= pending_nxt;
      rgb_q   <= (state_nxt == S_HIGH);
      busy_q  <= (state_nxt != S_IDLE);
      done_q  <= done_nxt;
    end
  end

  // Pixel shifter; always reloaded in LOAD before it is used.
  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end

  assign bus.rgb  = rgb_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
